// File: rtl/ccff_loader.sv
// Loads a serial configuration chain from a word-wide bitstream and can
// read the chain back once, comparing a CRC-8 of the readback against the load.
module ccff_loader #(
   parameter int CHAIN_LEN = 160,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic              verify_en,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              ccff_shift_en,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        crc_out
);

   localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int WC_W      = $clog2(NUM_WORDS + 1);
   localparam int BC_W      = $clog2(WORD_W + 1);

   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WC_W-1:0]  WORDS_MAX = WC_W'(NUM_WORDS);
   localparam logic [BC_W-1:0]  BUF_FULL  = BC_W'(WORD_W);
   localparam logic [BC_W-1:0]  BUF_ONE   = BC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_VERIFY,
      S_DONE
   } state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [WORD_W-1:0] word_buf;
   logic [BC_W-1:0]   buf_cnt;
   logic [7:0]        crc, crc_nxt, ref_crc;
   logic              verify_q;
   logic              last_bit;
   logic              xfer;

   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   assign last_bit = (bit_cnt == LAST_BIT);
   assign crc_nxt  = crc_step(crc, ccff_head);
   assign xfer     = cfg_valid && cfg_ready;
   assign crc_out  = crc;

   always_ff @(posedge prog_clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (prog_reset) state <= S_IDLE;
      else            state <= state_next;
   end

   // Outputs are gated by reset so the chain cannot shift in the reset cycle itself.
   always_comb begin
      // NOTE: every output gets a default first; otherwise an unassigned path infers a latch.
      state_next    = state;
      cfg_ready     = 1'b0;
      ccff_shift_en = 1'b0;
      ccff_head     = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      if (!prog_reset) begin
         unique case (state)
            S_IDLE: begin
               if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
               busy = 1'b1;
               if (buf_cnt != '0) begin
                  ccff_shift_en = 1'b1;
                  ccff_head     = word_buf[0];
               end
               cfg_ready = ((buf_cnt == '0) || (buf_cnt == BUF_ONE && ccff_shift_en))
                           && (word_cnt < WORDS_MAX);
               if (ccff_shift_en && last_bit)
                  state_next = verify_q ? S_VERIFY : S_DONE;
            end
            S_VERIFY: begin
               busy          = 1'b1;
               ccff_shift_en = 1'b1;
               ccff_head     = ccff_tail;
               if (last_bit) state_next = S_DONE;
            end
            S_DONE: begin
               done = 1'b1;
               if (start) state_next = S_LOAD;
            end
         endcase
      end
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         bit_cnt  <= '0;
         word_cnt <= '0;
         word_buf <= '0;
         buf_cnt  <= '0;
         crc      <= '0;
         ref_crc  <= '0;
         error    <= 1'b0;
         verify_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  bit_cnt  <= '0;
                  word_cnt <= '0;
                  word_buf <= '0;
                  buf_cnt  <= '0;
                  crc      <= '0;
                  error    <= 1'b0;
                  verify_q <= verify_en;
               end
            end
            S_LOAD: begin
               if (ccff_shift_en) begin
                  crc     <= crc_nxt;
                  bit_cnt <= bit_cnt + 1'b1;
               end
               if (xfer) begin
                  word_buf <= cfg_data;
                  buf_cnt  <= BUF_FULL;
                  word_cnt <= word_cnt + 1'b1;
               end else if (ccff_shift_en) begin
                  word_buf <= word_buf >> 1;
                  buf_cnt  <= buf_cnt - 1'b1;
               end
               // Final chain bit: drop any padding bits left in the last word.
               if (ccff_shift_en && last_bit) begin
                  word_buf <= '0;
                  buf_cnt  <= '0;
                  ref_crc  <= crc_nxt;
                  crc      <= '0;
                  if (verify_q) bit_cnt <= '0;
               end
            end
            S_VERIFY: begin
               crc     <= crc_nxt;
               bit_cnt <= bit_cnt + 1'b1;
               if (last_bit) error <= (crc_nxt != ref_crc);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: models the configuration chain as a shift register
// and checks load, verify, corruption, stall, padding, restart and reset behaviour.
module tb_ccff_loader;

   localparam int CL = 20;
   localparam int WW = 8;
   localparam logic [CL-1:0] FLIP_MASK = 20'h00020;

   logic          prog_clk = 1'b0;
   logic          prog_reset;
   logic          start;
   logic          verify_en;
   logic [WW-1:0] cfg_data;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          ccff_head;
   logic          ccff_tail;
   logic          ccff_shift_en;
   logic          busy;
   logic          done;
   logic          error;
   logic [7:0]    crc_out;

   logic [CL-1:0] chain = '0;
   logic [CL-1:0] chain_flip;
   logic          flip_req = 1'b0;
   int            shift_total = 0;
   int            hs_total = 0;
   int            tests = 0;
   int            failed = 0;

   always #5 prog_clk = ~prog_clk;

   ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk      (prog_clk),
      .prog_reset    (prog_reset),
      .start         (start),
      .verify_en     (verify_en),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail),
      .ccff_shift_en (ccff_shift_en),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .crc_out       (crc_out)
   );

   // Chain model: chain[0] is the head flop, chain[CL-1] drives the tail.
   assign ccff_tail  = chain[CL-1];
   assign chain_flip = flip_req ? (chain ^ FLIP_MASK) : chain;

   always @(posedge prog_clk) begin
      chain <= ccff_shift_en ? {chain_flip[CL-2:0], ccff_head} : chain_flip;
      if (ccff_shift_en)           shift_total <= shift_total + 1;
      if (cfg_valid && cfg_ready)  hs_total    <= hs_total + 1;
   end

   typedef struct {
      string        name;
      logic [7:0]   w0, w1, w2;
      logic         ver;
      int           stall;
      logic         flip;
      int           restart_at;
      int           exp_shifts;
      int           exp_bub;
      logic         exp_err;
      logic [CL-1:0] exp_chain;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // CRC-8 (poly 0x07) over the chain read tail first, i.e. stream bit 0 first.
   function automatic logic [7:0] crc_model(input logic [CL-1:0] c);
      logic [7:0] r;
      logic       fb;
      r = 8'h00;
      for (int k = CL - 1; k >= 0; k--) begin
         fb = r[7] ^ c[k];
         r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return r;
   endfunction

   task automatic run_vec(input vec_t v);
      int         base_s, base_h, bubbles, hs, stall_left;
      bit         reached, flipped;
      logic [7:0] words [3];
      words[0]   = v.w0;
      words[1]   = v.w1;
      words[2]   = v.w2;
      base_s     = shift_total;
      base_h     = hs_total;
      bubbles    = 0;
      stall_left = v.stall;
      reached    = 1'b0;
      flipped    = 1'b0;
      @(negedge prog_clk);
      start     = 1'b1;
      verify_en = v.ver;
      cfg_valid = 1'b1;
      cfg_data  = v.w0;
      @(negedge prog_clk);
      start     = 1'b0;
      verify_en = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         hs        = hs_total - base_h;
         start     = ((shift_total - base_s) == v.restart_at);
         verify_en = start;
         flip_req  = 1'b0;
         if (v.flip && !flipped && (shift_total - base_s) == CL) begin
            flip_req = 1'b1;
            flipped  = 1'b1;
         end
         if (hs < 3) begin
            cfg_data = words[hs];
            if (hs == 1 && stall_left > 0 && cfg_ready) begin
               cfg_valid = 1'b0;
               stall_left--;
            end else begin
               cfg_valid = 1'b1;
            end
         end else begin
            cfg_valid = 1'b0;
            cfg_data  = '0;
         end
         if (busy && !ccff_shift_en && shift_total != base_s) bubbles++;
         @(posedge prog_clk);
         #1;
         if ((shift_total - base_s) == v.exp_shifts) begin
            reached = 1'b1;
            break;
         end
         @(negedge prog_clk);
      end
      flip_req  = 1'b0;
      start     = 1'b0;
      verify_en = 1'b0;
      cfg_valid = 1'b0;
      check({v.name, ".reached"}, 32'(reached), 32'd1);
      @(negedge prog_clk);
      check({v.name, ".done"},      32'(done),          32'd1);
      check({v.name, ".busy"},      32'(busy),          32'd0);
      check({v.name, ".shift_en"},  32'(ccff_shift_en), 32'd0);
      check({v.name, ".cfg_ready"}, 32'(cfg_ready),     32'd0);
      check({v.name, ".handshakes"}, hs_total - base_h, 32'd3);
      check({v.name, ".bubbles"},   bubbles,            v.exp_bub);
      check({v.name, ".chain"},     32'(chain),         32'(v.exp_chain));
      check({v.name, ".error"},     32'(error),         32'(v.exp_err));
      if (v.ver) check({v.name, ".crc"}, 32'(crc_out), 32'(crc_model(v.exp_chain)));
      repeat (3) @(negedge prog_clk);
      check({v.name, ".done_hold"}, 32'(done),          32'd1);
      check({v.name, ".shifts"},    shift_total - base_s, v.exp_shifts);
   endtask

   initial begin
      int         base_s, base_h, hs;
      logic [7:0] words [3];

      //          name       w0     w1     w2     ver   stall flip  rst  shifts bub err   chain
      vecs[0] = '{"load",    8'hA5, 8'h3C, 8'h0F, 1'b0, 0,    1'b0, -1,  20,    0,  1'b0, 20'hA53CF};
      vecs[1] = '{"verify",  8'hA5, 8'h3C, 8'h0F, 1'b1, 0,    1'b0, -1,  40,    0,  1'b0, 20'hA53CF};
      vecs[2] = '{"corrupt", 8'hA5, 8'h3C, 8'h0F, 1'b1, 0,    1'b1, -1,  40,    0,  1'b1, 20'hA53EF};
      vecs[3] = '{"stall",   8'hA5, 8'h3C, 8'h0F, 1'b0, 3,    1'b0, -1,  20,    3,  1'b0, 20'hA53CF};
      vecs[4] = '{"pad",     8'h5A, 8'hC3, 8'hF6, 1'b1, 2,    1'b0, -1,  40,    2,  1'b0, 20'h5AC36};
      vecs[5] = '{"restart", 8'hA5, 8'h3C, 8'h0F, 1'b0, 0,    1'b0, 5,   20,    0,  1'b0, 20'hA53CF};

      prog_reset = 1'b1;
      start      = 1'b0;
      verify_en  = 1'b0;
      cfg_valid  = 1'b1;
      cfg_data   = 8'hFF;
      repeat (3) @(negedge prog_clk);
      check("rst.busy",      32'(busy),          32'd0);
      check("rst.done",      32'(done),          32'd0);
      check("rst.cfg_ready", 32'(cfg_ready),     32'd0);
      check("rst.shift_en",  32'(ccff_shift_en), 32'd0);
      check("rst.head",      32'(ccff_head),     32'd0);
      check("rst.error",     32'(error),         32'd0);
      check("rst.crc",       32'(crc_out),       32'd0);
      prog_reset = 1'b0;
      base_h     = hs_total;
      repeat (3) @(negedge prog_clk);
      check("idle.cfg_ready",  32'(cfg_ready), 32'd0);
      check("idle.no_xfer",    hs_total - base_h, 32'd0);
      check("idle.done",       32'(done), 32'd0);
      cfg_valid = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset in the middle of a load: abort at the tenth shift, start ignored.
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[2] = 8'h0F;
      base_s   = shift_total;
      @(negedge prog_clk);
      start     = 1'b1;
      verify_en = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = words[0];
      @(negedge prog_clk);
      start     = 1'b0;
      verify_en = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if ((shift_total - base_s) == 10) break;
         hs        = hs_total - base_h;
         hs        = (hs > 2) ? 2 : hs;
         cfg_data  = words[hs];
         @(negedge prog_clk);
      end
      check("mid.shifts", shift_total - base_s, 32'd10);
      prog_reset = 1'b1;
      start      = 1'b1;
      #1;
      check("mid.gate_shift", 32'(ccff_shift_en), 32'd0);
      @(posedge prog_clk);
      #1;
      check("mid.no_shift_at_reset", shift_total - base_s, 32'd10);
      @(negedge prog_clk);
      prog_reset = 1'b0;
      start      = 1'b0;
      #1;
      check("mid.busy",      32'(busy),          32'd0);
      check("mid.done",      32'(done),          32'd0);
      check("mid.cfg_ready", 32'(cfg_ready),     32'd0);
      check("mid.shift_en",  32'(ccff_shift_en), 32'd0);
      check("mid.head",      32'(ccff_head),     32'd0);
      check("mid.error",     32'(error),         32'd0);
      check("mid.crc",       32'(crc_out),       32'd0);
      base_h = hs_total;
      repeat (10) @(negedge prog_clk);
      check("mid.stays_idle",  32'(busy),           32'd0);
      check("mid.no_more",     shift_total - base_s, 32'd10);
      check("mid.no_xfer",     hs_total - base_h,    32'd0);
      cfg_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 160, number of configuration flip-flops in the downstream ccff chain (must be >= 2).
REQ-002 Parameter WORD_W, default 8, width of each bitstream word (must be 1 to 32).
REQ-003 Clocking: one clock, prog_clk; reset is prog_reset, synchronous and active-high.
REQ-004 prog_clk  in  1  configuration clock; every flop in the block is on the rising edge.
REQ-005 prog_reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-007 verify_en  in  1  sampled with start; 1 = run the VERIFY pass after LOAD.
REQ-008 cfg_data  in  WORD_W  bitstream word, shifted LSB first.
REQ-009 cfg_valid  in  1  cfg_data is valid.
REQ-010 cfg_ready  out  1  the block accepts cfg_data this cycle.
REQ-011 ccff_head  out  1  serial data into the chain head.
REQ-012 ccff_tail  in  1  serial data from the chain tail.
REQ-013 ccff_shift_en  out  1  chain clock enable; the chain shifts once per prog_clk edge while this is 1.
REQ-014 busy  out  1  high in LOAD or VERIFY.
REQ-015 done  out  1  high in DONE.
REQ-016 error  out  1  sticky verify-mismatch flag, valid while done=1.
REQ-017 crc_out  out  8  current CRC accumulator (debug).

Function
REQ-018 FSM states: IDLE, LOAD, VERIFY, DONE.
REQ-019 IDLE or DONE + start=1 -> LOAD; this also clears the bit counter, word buffer, CRC, error and the latched verify_en.
REQ-020 LOAD: a word transfers on cfg_valid && cfg_ready and fills a WORD_W-bit buffer with bit count WORD_W.
REQ-021 LOAD cfg_ready = 1 when all of the following hold:
- buffer count is 0, or buffer count is 1 with a shift occurring this cycle;
- words accepted < ceil(CHAIN_LEN/WORD_W).
REQ-022 LOAD shift cycle: when the buffer is non-empty and bits shifted < CHAIN_LEN:
- ccff_shift_en = 1 and ccff_head = buffer[0];
- the buffer shifts right and the bit count decrements.
REQ-023 LOAD stall: an empty buffer forces ccff_shift_en = 0 and ccff_head = 0; the chain contents hold.
REQ-024 With cfg_valid held high, one bit is shifted every cycle, with no bubble at word boundaries.
REQ-025 Last-word padding: when CHAIN_LEN is not a multiple of WORD_W, the unused upper bits of the last word are discarded.
- Discarded bits are never shifted and do not enter the CRC.
- The buffer is cleared when the CHAIN_LEN-th bit shifts.
REQ-026 CRC-8 per shifted bit b, polynomial 0x07, init 0x00:
- fb = crc[7]^b;
- crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
REQ-027 After the CHAIN_LEN-th shift, the next state is VERIFY if the latched verify_en is 1, otherwise DONE.
- The reference CRC is latched at this transition and the CRC accumulator is cleared.
REQ-028 VERIFY lasts exactly CHAIN_LEN cycles, each of which:
- drives ccff_shift_en = 1 and ccff_head = ccff_tail, so chain contents are restored after the pass;
- feeds ccff_tail into the CRC.
REQ-029 End of VERIFY -> DONE; error = (CRC != latched reference CRC).
REQ-030 DONE: ccff_shift_en = 0, cfg_ready = 0, done = 1; the state holds until start or reset.
REQ-031 start while busy = 1 is ignored.
REQ-032 cfg_valid outside LOAD is ignored: cfg_ready = 0 and no transfer occurs.
REQ-033 Bit counter width is clog2(CHAIN_LEN+1); the counter never wraps.

Reset
REQ-034 prog_reset = 1 at a clock edge forces, at that edge:
- state IDLE, all counters and the buffer 0, crc 0, error 0;
- busy, done, cfg_ready, ccff_shift_en and ccff_head all 0.
REQ-035 Reset mid-LOAD or mid-VERIFY aborts immediately; no further chain shifts occur, and the partial chain contents are undefined and must be reloaded.
REQ-036 Reset overrides start presented in the same cycle.

Verification
REQ-037 The bench models the chain as a CHAIN_LEN-flop shift register enabled by ccff_shift_en. All scenarios below use CHAIN_LEN = 20 and WORD_W = 8.
REQ-038 Load, no verify: start with verify_en = 0, words 0xA5, 0x3C, 0x0F, cfg_valid held high.
- Exactly 20 shift cycles occur, with 3 handshakes and no bubble.
- The chain holds bits 0..19 of that stream; done = 1 on the cycle after the last shift.
REQ-039 Verify pass: same load with verify_en = 1.
- 20 more shift cycles occur; the chain is unchanged afterwards.
- error = 0 and crc_out equals the reference CRC.
REQ-040 Corruption: same load as REQ-039, but the bench flips chain bit 5 after LOAD -> error = 1 at DONE.
REQ-041 Stall: cfg_valid is low for 3 cycles between word 1 and word 2.
- ccff_shift_en = 0 for exactly those 3 cycles.
- The final chain contents are identical to REQ-038.
REQ-042 Reset and start rules:
- prog_reset asserted at shift 10 -> all outputs 0 on the next cycle and no further shifts;
- a start pulse while busy does not restart the load.
